// File: rtl/seg7_scan.sv
// seg7_scan: double-buffered 4-digit multiplexed 7-segment scan driver.
// Ports: clk, rst_n, load/bcd_in/dp_in/lz_blank in; seg_out, dp_out, dig_en, frame_done out.
module seg7_scan #(
    parameter int CLK_FREQ     = 27_000_000,
    parameter int DIGIT_HZ     = 1000,
    parameter int BLANK_CYCLES = 270,
    parameter bit COMMON_ANODE = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] bcd_in,
    input  logic [3:0]  dp_in,
    input  logic        lz_blank,
    output logic [6:0]  seg_out,
    output logic        dp_out,
    output logic [3:0]  dig_en,
    output logic        frame_done
);

    localparam int TICK = CLK_FREQ / DIGIT_HZ;
    localparam int CW   = (TICK > 1) ? $clog2(TICK) : 1;

    localparam logic [CW-1:0] LAST = CW'(TICK - 1);
    localparam logic [CW-1:0] BLK  = CW'(BLANK_CYCLES);

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    localparam state_t SLOT_START = (BLANK_CYCLES == 0) ? DRIVE : BLANK;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [1:0]    idx;
    state_t        state;
    logic [15:0]   sh_bcd;
    logic [3:0]    sh_dp;
    logic [15:0]   act_bcd;
    logic [3:0]    act_dp;
    logic          pending;

    logic          wrap;
    logic          boundary;
    logic [3:0]    digit;
    logic [3:0]    zero;
    logic          supp;
    logic [6:0]    seg_c;
    logic          dp_c;
    logic [3:0]    en_c;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b1000000;
        endcase
        return s;
    endfunction

    assign wrap     = (cnt == LAST);
    assign boundary = wrap && (idx == 2'd3);
    assign cnt_nxt  = wrap ? '0 : cnt + 1'b1;

    always_comb begin
        digit = act_bcd[{idx, 2'b00} +: 4];
        for (int k = 0; k < 4; k++) begin
            zero[k] = (act_bcd[4*k +: 4] == 4'd0);
        end
        // A digit is blanked only when it and every digit above it are zero.
        unique case (idx)
            2'd3:    supp = zero[3];
            2'd2:    supp = &zero[3:2];
            2'd1:    supp = &zero[3:1];
            default: supp = 1'b0;
        endcase
        supp  = supp & lz_blank;
        seg_c = '0;
        dp_c  = 1'b0;
        en_c  = '0;
        if (state == DRIVE) begin
            en_c  = 4'b0001 << idx;
            seg_c = supp ? 7'd0 : decode(digit);
            dp_c  = act_dp[idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            state      <= SLOT_START;
            sh_bcd     <= '0;
            sh_dp      <= '0;
            act_bcd    <= '0;
            act_dp     <= '0;
            pending    <= 1'b0;
            seg_out    <= {7{COMMON_ANODE}};
            dp_out     <= COMMON_ANODE;
            dig_en     <= {4{COMMON_ANODE}};
            frame_done <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (wrap) begin
                idx   <= idx + 2'd1;
                state <= SLOT_START;
            end else if (cnt_nxt == BLK) begin
                state <= DRIVE;
            end
            // Boundary transfer uses the old shadow even if load hits the same edge.
            if (boundary && pending) begin
                act_bcd <= sh_bcd;
                act_dp  <= sh_dp;
            end
            if (load) begin
                sh_bcd  <= bcd_in;
                sh_dp   <= dp_in;
                pending <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
            seg_out    <= seg_c ^ {7{COMMON_ANODE}};
            dp_out     <= dp_c ^ COMMON_ANODE;
            dig_en     <= en_c ^ {4{COMMON_ANODE}};
            frame_done <= boundary;
        end
    end

endmodule
